custom_crc6_unit: RTL and testbench
===================================

# custom_crc6_unit

Multi-cycle execution unit for the CUSTOM0 instruction (opcode 1101011, funct3 000, funct7 0000000): computes a CRC-6 of rs1 seeded by rs2 and returns it for write-back to rd. Sits in the execute stage, downstream of the decoder, which presents decoded custom-opcode instructions with their operands. Ready/valid handshakes on the issue and result sides. Also rejects CUSTOM1/CUSTOM2 and any other unsupported encoding on that opcode as illegal.

## Interface
- BITS_PER_CYCLE, 1: data bits folded per BUSY cycle; legal values 1, 2, 4, 8, 16, 32.
- POLY, 6'h03: CRC-6 polynomial, x^6 term implicit (x^6+x+1).
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  decoder presents a custom-opcode instruction.
- o_ready  out  1  unit can accept; high only in IDLE.
- i_instr  in  32  full instruction word; funct7 = [31:25], funct3 = [14:12].
- i_rs1  in  32  data operand.
- i_rs2  in  32  seed; only [5:0] used.
- i_flush  in  1  pipeline flush; aborts any operation.
- o_valid  out  1  result/exception available.
- i_ready  in  1  write-back accepts result.
- o_result  out  32  {26'b0, crc[5:0]}; 0 when o_illegal.
- o_illegal  out  1  qualifies o_valid: unsupported encoding.
- o_busy  out  1  high in BUSY or DONE.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: o_ready=1. Accept on i_valid & o_ready & !i_flush. The unit registers rs1 into a data shift register, rs2[5:0] into crc, and clears the count.
  - If funct3==000 and funct7==0: go to BUSY.
  - Otherwise: go to DONE with illegal flag set and crc cleared.
- BUSY: each cycle folds BITS_PER_CYCLE bits, MSB first.
  - Per bit b: fb = crc[5]^b; crc = {crc[4:0],1'b0} ^ (fb ? POLY : 0).
  - Data shift register shifts left by BITS_PER_CYCLE.
  - After N = 32/BITS_PER_CYCLE cycles, go to DONE.
- DONE: o_valid=1 and o_result/o_illegal stay stable until i_ready. On i_ready, go to IDLE. No new accept occurs in the same cycle, because o_ready=0 in DONE.
- i_flush in any state: go to IDLE next edge. No o_valid is produced for the aborted operation, and the result is discarded. Flush coincident with i_valid in IDLE: flush wins, nothing is accepted.
- i_rst: state IDLE, crc/data/count/illegal cleared. Applies mid-operation identically.
- All width arithmetic is 6-bit, with no carry.
- Count width is clog2(32/BITS_PER_CYCLE)+1.

## Timing
- Reset values: o_ready=1, o_valid=0, o_result=0, o_illegal=0, o_busy=0.
- Accept at edge k: BUSY from k. o_valid rises after edge k+N: 32 cycles for BITS_PER_CYCLE=1, 1 cycle for 32.
- Illegal accept at edge k: o_valid=1, o_illegal=1 after edge k+1.
- Result held indefinitely while i_ready=0.
- Handshake completes on the edge where o_valid & i_ready. o_valid=0 and o_ready=1 after that edge.
- Minimum issue interval: N+2 cycles (accept, N BUSY, one DONE handshake cycle).
- Outputs are registered. There is no combinational path from i_valid/i_ready to o_ready/o_valid.

## Configuration
- CUSTOM_CRC6_REFIN_EN defined: data bits are folded LSB first (data register shifts right, bit 0 first). The CRC output is not reflected.
- CUSTOM_CRC6_REFIN_EN undefined: data bits are folded MSB first, as described under Operation.
- Latency, handshake and illegal handling are identical in both builds.

## Test plan
- Reset: hold i_rst 2 cycles, then release. Outputs match the reset values; o_ready=1.
- Basic CRC, BITS_PER_CYCLE=1, MSB-first build: CUSTOM0 with rs1=32'h00000001, rs2=0 -> o_result=32'h3 after 32 cycles. Then rs1=32'h00000020, rs2=0 -> 32'h23. Then rs1=0, rs2=32'hFFFFFFC0 -> 32'h0 (upper seed bits ignored).
- Parameter sweep, 1/2/4/8/16/32: same vectors -> same results; o_valid latency equals 32/BITS_PER_CYCLE.
- Illegal encodings: funct3=001, then 010, then funct7=0000001 with funct3=000 -> o_valid & o_illegal after 1 cycle, o_result=0.
- Backpressure and flush:
  - hold i_ready=0 for 10 cycles in DONE -> o_result stable, o_ready=0.
  - i_flush at BUSY cycle 5 -> IDLE next cycle, no o_valid; a subsequent CUSTOM0 computes correctly.
  - i_rst mid-BUSY -> reset values next cycle.
- Reflected build (CUSTOM_CRC6_REFIN_EN): rs1=32'h80000000, rs2=0 -> 32'h3; rs1=32'h04000000, rs2=0 -> 32'h23.

Source files
------------

// File: rtl/custom_crc6_unit_if.sv
// ---------------------------------------------------------------------------
// custom_crc6_unit_if
// Issue/result handshake bundle between the decoder, custom_crc6_unit and
// write-back. Signal names are seen from the unit: i_* flow into it, o_*
// flow out of it.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface custom_crc6_unit_if;
  // issue side
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic        i_flush;
  // result side
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_illegal;
  logic        o_busy;

  // decoder / write-back side
  modport master (
    output i_valid, i_instr, i_rs1, i_rs2, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_illegal, o_busy
  );

  // execution unit side
  modport slave (
    input  i_valid, i_instr, i_rs1, i_rs2, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_illegal, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/custom_crc6_unit.sv
// ---------------------------------------------------------------------------
// custom_crc6_unit
// Multi-cycle CUSTOM0 execution unit: CRC-6 of rs1 seeded by rs2[5:0],
// folding BITS_PER_CYCLE data bits per BUSY cycle. Non-CUSTOM0 encodings
// (funct3/funct7 not all zero) complete in one cycle as illegal.
// Build option: CUSTOM_CRC6_REFIN_EN folds data bits LSB first instead of
// MSB first; the CRC output itself is never reflected.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module custom_crc6_unit #(
  parameter int         BITS_PER_CYCLE = 1,
  parameter logic [5:0] POLY           = 6'h03
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst,
  custom_crc6_unit_if.slave   bus
);

  localparam int N     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [5:0]         crc;
  logic [31:0]        data_sr;
  logic [CNT_W-1:0]   count;
  logic               illegal;
  logic [5:0]         crc_fold;
  logic [31:0]        data_fold;
  logic               accept;
  logic               legal;
  logic               last_step;
  logic               unused_bits;

  assign accept    = (state == IDLE) && bus.i_valid && !bus.i_flush;
  assign legal     = (bus.i_instr[14:12] == 3'b000) && (bus.i_instr[31:25] == 7'b0000000);
  assign last_step = (count == CNT_W'(N - 1));

  // Operand fields the unit never looks at (register indices, opcode, seed MSBs).
  assign unused_bits = ^{bus.i_instr[24:15], bus.i_instr[11:0], bus.i_rs2[31:6]};

  // Fold BITS_PER_CYCLE data bits into the CRC, one bit at a time.
  always_comb begin
    logic b;
    logic fb;
    crc_fold  = crc;
    data_fold = data_sr;
    b         = 1'b0;
    fb        = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef CUSTOM_CRC6_REFIN_EN
      b         = data_fold[0];
      data_fold = {1'b0, data_fold[31:1]};
`else
      b         = data_fold[31];
      data_fold = {data_fold[30:0], 1'b0};
`endif
      fb       = crc_fold[5] ^ b;
      crc_fold = {crc_fold[4:0], 1'b0} ^ (fb ? POLY : 6'd0);
    end
  end

  // Next-state decode; flush always returns to IDLE and wins over an accept.
  always_comb begin
    state_next = state;
    if (bus.i_flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.i_valid) state_next = legal ? BUSY : DONE;
        BUSY:    if (last_step)   state_next = DONE;
        DONE:    if (bus.i_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register and datapath: capture on accept, fold while BUSY.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      crc     <= 6'd0;
      data_sr <= 32'd0;
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        data_sr <= bus.i_rs1;
        count   <= '0;
        if (legal) begin
          crc     <= bus.i_rs2[5:0];
          illegal <= 1'b0;
        end else begin
          crc     <= 6'd0;
          illegal <= 1'b1;
        end
      end else if ((state == BUSY) && !bus.i_flush) begin
        crc     <= crc_fold;
        data_sr <= data_fold;
        count   <= count + CNT_W'(1);
      end
    end
  end

  // All outputs decode registered state only.
  assign bus.o_ready   = (state == IDLE);
  assign bus.o_valid   = (state == DONE);
  assign bus.o_busy    = (state != IDLE);
  assign bus.o_illegal = illegal;
  assign bus.o_result  = {26'd0, crc};

endmodule

`default_nettype wire

// File: tb/tb_custom_crc6_unit.sv
// ---------------------------------------------------------------------------
// tb_custom_crc6_unit
// Scoreboard bench for custom_crc6_unit: expected results are queued at
// issue and compared when the unit presents them.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_custom_crc6_unit;

  parameter int BPC = 1;
  localparam int N = 32 / BPC;

  typedef struct {
    logic [31:0] result;
    logic        illegal;
    int          lat;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  custom_crc6_unit_if bus();

  custom_crc6_unit #(.BITS_PER_CYCLE(BPC), .POLY(6'h03)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference CRC-6 (x^6+x+1), bit-serial over all 32 data bits.
  function automatic logic [5:0] crc_model(input logic [31:0] d, input logic [31:0] s);
    logic [5:0] c;
    logic       b;
    logic       fb;
    c = s[5:0];
    for (int i = 0; i < 32; i++) begin
`ifdef CUSTOM_CRC6_REFIN_EN
      b = d[i];
`else
      b = d[31 - i];
`endif
      fb = c[5] ^ b;
      c  = {c[4:0], 1'b0} ^ (fb ? 6'h03 : 6'h00);
    end
    return c;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd3, f3, 5'd1, 7'b1101011};
  endfunction

  // Present one instruction, wait for the accept edge, optionally queue expectation.
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                       input bit push, input logic [31:0] exp_res, input string tag);
    bit   lgl;
    exp_t e;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, bus.o_ready}, 32'd1);
    bus.i_valid = 1'b1;
    bus.i_instr = instr;
    bus.i_rs1   = rs1;
    bus.i_rs2   = rs2;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    if (push) begin
      lgl       = (instr[14:12] == 3'b000) && (instr[31:25] == 7'b0000000);
      e.result  = lgl ? exp_res : 32'd0;
      e.illegal = !lgl;
      e.lat     = lgl ? N : 1;
      e.tag     = tag;
      sb.push_back(e);
    end
  endtask

  // Wait for o_valid, compare against the scoreboard head, hold, then handshake.
  task automatic collect(input int hold);
    int          lat;
    exp_t        e;
    logic [31:0] r0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.o_valid && lat < 200);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (!bus.o_valid) begin
      check({e.tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({e.tag, "_lat"}, lat, e.lat);
    check({e.tag, "_result"}, bus.o_result, e.result);
    check({e.tag, "_illegal"}, {31'd0, bus.o_illegal}, {31'd0, e.illegal});
    check({e.tag, "_noready"}, {31'd0, bus.o_ready}, 32'd0);
    r0 = bus.o_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({e.tag, "_hold_result"}, bus.o_result, r0);
      check({e.tag, "_hold_valid"}, {31'd0, bus.o_valid}, 32'd1);
      check({e.tag, "_hold_ready"}, {31'd0, bus.o_ready}, 32'd0);
    end
    @(negedge clk);
    bus.i_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_ready = 1'b0;
    check({e.tag, "_hs_valid"}, {31'd0, bus.o_valid}, 32'd0);
    check({e.tag, "_hs_ready"}, {31'd0, bus.o_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   {31'd0, bus.o_ready},   32'd1);
    check({tag, "_valid"},   {31'd0, bus.o_valid},   32'd0);
    check({tag, "_result"},  bus.o_result,           32'd0);
    check({tag, "_illegal"}, {31'd0, bus.o_illegal}, 32'd0);
    check({tag, "_busy"},    {31'd0, bus.o_busy},    32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] c0;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] a;
    logic [31:0] s;
    int          stop_at;
    int          seen;

    c0 = mk_instr(7'd0, 3'd0);
`ifdef CUSTOM_CRC6_REFIN_EN
    v1 = 32'h8000_0000;
    v2 = 32'h0400_0000;
`else
    v1 = 32'h0000_0001;
    v2 = 32'h0000_0020;
`endif
    stop_at = (N > 5) ? 5 : N - 1;

    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_instr = 32'd0;
    bus.i_rs1   = 32'd0;
    bus.i_rs2   = 32'd0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Known vectors
    issue(c0, v1, 32'd0, 1'b1, 32'h3, "crc_a");
    collect(0);
    issue(c0, v2, 32'd0, 1'b1, 32'h23, "crc_b");
    collect(0);
    issue(c0, 32'd0, 32'hFFFF_FFC0, 1'b1, 32'h0, "crc_seedmask");
    collect(10);

    // Random operands against the reference model
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      s = $urandom;
      issue(c0, a, s, 1'b1, {26'd0, crc_model(a, s)}, $sformatf("crc_rnd%0d", i));
      collect(i);
    end

    // Illegal encodings
    issue(mk_instr(7'd0, 3'b001), 32'h1234_5678, 32'h3F, 1'b1, 32'd0, "ill_f3_1");
    collect(0);
    issue(mk_instr(7'd0, 3'b010), 32'h1234_5678, 32'h3F, 1'b1, 32'd0, "ill_f3_2");
    collect(2);
    issue(mk_instr(7'd1, 3'b000), 32'h1234_5678, 32'h3F, 1'b1, 32'd0, "ill_f7");
    collect(0);

    // Flush coincident with issue: nothing accepted
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_instr = c0;
    bus.i_rs1   = v1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    check("flush_issue_ready", {31'd0, bus.o_ready}, 32'd1);
    check("flush_issue_busy",  {31'd0, bus.o_busy},  32'd0);

    // Flush mid-BUSY: back to IDLE, no result ever appears
    issue(c0, 32'hDEAD_BEEF, 32'h15, 1'b0, 32'd0, "flush_op");
    repeat (stop_at) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    check("flush_busy",  {31'd0, bus.o_busy},  32'd0);
    check("flush_ready", {31'd0, bus.o_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < N + 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_valid) seen++;
    end
    check("flush_novalid", seen, 32'd0);
    issue(c0, v2, 32'd0, 1'b1, 32'h23, "after_flush");
    collect(0);

    // Reset mid-BUSY
    issue(c0, 32'hCAFE_F00D, 32'h2A, 1'b0, 32'd0, "rst_op");
    repeat (stop_at) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    issue(c0, v1, 32'd0, 1'b1, 32'h3, "after_rst");
    collect(0);

    check("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
